// File: rtl/clk_divider_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_divider_mc : multi-channel programmable clock divider with shadowed   |
// | ratios that take effect only at period boundaries.                        |
// | Optional macro CLK_DIV_ODD50_EN: 50% duty for odd ratios (falling edge).   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module clk_divider_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 2
) (
    input  logic                           clk_in,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            enable,
    input  logic [CHANNELS*DATA_WIDTH-1:0] div_ratio,
    input  logic                           load,
    output logic [CHANNELS-1:0]            clk_out,
    output logic [CHANNELS-1:0]            tick
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        state_t                state;
        logic [DATA_WIDTH-1:0] shadow;
        logic [DATA_WIDTH-1:0] active;
        logic [DATA_WIDTH-1:0] cnt;
        logic [DATA_WIDTH-1:0] high_len;
        logic                  shadow_ok;
        logic                  pos_out;
        logic                  tick_q;

        // A ratio is usable only when it is 2 or more.
        assign shadow_ok = |shadow[DATA_WIDTH-1:1];

`ifdef CLK_DIV_ODD50_EN
        // Posedge phase is ceil(N/2); the falling-edge AND trims half a cycle on odd N.
        assign high_len = active - (active >> 1);
`else
        assign high_len = active >> 1;
`endif

        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                state   <= ST_IDLE;
                shadow  <= '0;
                active  <= '0;
                cnt     <= '0;
                pos_out <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                if (load) begin
                    shadow <= div_ratio[k*DATA_WIDTH +: DATA_WIDTH];
                end
                case (state)
                    ST_IDLE: begin
                        cnt     <= '0;
                        pos_out <= 1'b0;
                        tick_q  <= 1'b0;
                        if (enable[k] && shadow_ok) begin
                            state   <= ST_RUN;
                            active  <= shadow;
                            pos_out <= 1'b1;
                            tick_q  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (cnt != active - 1'b1) begin
                            cnt     <= cnt + 1'b1;
                            pos_out <= (cnt + 1'b1) < high_len;
                            tick_q  <= 1'b0;
                        end else if (enable[k] && shadow_ok) begin
                            active  <= shadow;
                            cnt     <= '0;
                            pos_out <= 1'b1;
                            tick_q  <= 1'b1;
                        end else begin
                            state   <= ST_IDLE;
                            cnt     <= '0;
                            pos_out <= 1'b0;
                            tick_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end

`ifdef CLK_DIV_ODD50_EN
        logic neg_out;

        always_ff @(negedge clk_in or posedge reset) begin
            if (reset) begin
                neg_out <= 1'b0;
            end else begin
                neg_out <= pos_out;
            end
        end

        assign clk_out[k] = active[0] ? (pos_out & neg_out) : pos_out;
`else
        assign clk_out[k] = pos_out;
`endif
        assign tick[k] = tick_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_divider_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_clk_divider_mc : scoreboard bench for clk_divider_mc (2 x 8-bit).      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_clk_divider_mc;

    logic        clk_in;
    logic        reset;
    logic [1:0]  enable;
    logic [15:0] div_ratio;
    logic        load;
    logic [1:0]  clk_out;
    logic [1:0]  tick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Per-channel expected {clk_out, tick} after each rising edge.
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic [1:0] e0;
    logic [1:0] e1;

    clk_divider_mc #(
        .DATA_WIDTH(8),
        .CHANNELS  (2)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .enable   (enable),
        .div_ratio(div_ratio),
        .load     (load),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int ch, input logic [1:0] v);
        if (ch == 0) q0.push_back(v);
        else         q1.push_back(v);
    endtask

    task automatic exp_idle(input int ch, input int m);
        for (int i = 0; i < m; i++) push(ch, 2'b00);
    endtask

    // One full output period of ratio n as seen just after each rising edge.
    task automatic exp_period(input int ch, input int n);
        logic hi;
        for (int i = 0; i < n; i++) begin
`ifdef CLK_DIV_ODD50_EN
            if (n % 2 == 1) hi = (i >= 1) && (i <= n / 2);
            else            hi = (i < n / 2);
`else
            hi = (i < n / 2);
`endif
            push(ch, {hi, (i == 0)});
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    always @(posedge clk_in) begin
        #1;
        cyc++;
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            check($sformatf("ch0_clk c%0d", cyc), 32'(clk_out[0]), 32'(e0[1]));
            check($sformatf("ch0_tick c%0d", cyc), 32'(tick[0]), 32'(e0[0]));
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            check($sformatf("ch1_clk c%0d", cyc), 32'(clk_out[1]), 32'(e1[1]));
            check($sformatf("ch1_tick c%0d", cyc), 32'(tick[1]), 32'(e1[0]));
        end
    end

    initial begin
        reset     = 1'b1;
        enable    = 2'b00;
        load      = 1'b0;
        div_ratio = '0;
        #1;
        check("reset_clk", 32'(clk_out), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        #7 reset = 1'b0;
        @(negedge clk_in);

        // Both channels: ch0 ratio 2, ch1 ratio 4.
        div_ratio = {8'd4, 8'd2}; load = 1'b1;
        exp_idle(0, 1); exp_idle(1, 1);
        step(1);
        load = 1'b0; enable = 2'b11;
        repeat (4) exp_period(0, 2);
        repeat (2) exp_period(1, 4);
        step(8);
        enable = 2'b00;
        exp_idle(0, 2); exp_idle(1, 2);
        step(2);

        // Ratio change mid-period applies only at the wrap.
        div_ratio = {8'd0, 8'd6}; load = 1'b1;
        exp_idle(0, 1); exp_idle(1, 1);
        step(1);
        load = 1'b0; enable = 2'b01;
        exp_period(0, 6); exp_period(0, 10); exp_idle(1, 16);
        step(3);
        div_ratio = {8'd0, 8'd10}; load = 1'b1;
        step(1);
        load = 1'b0;
        step(12);
        enable = 2'b00;
        exp_idle(0, 2); exp_idle(1, 2);
        step(2);

        // Enable dropped at cnt=1 of a ratio-5 period.
        div_ratio = {8'd0, 8'd5}; load = 1'b1;
        exp_idle(0, 1); exp_idle(1, 1);
        step(1);
        load = 1'b0; enable = 2'b01;
        exp_period(0, 5); exp_idle(0, 3); exp_idle(1, 8);
        step(2);
        enable = 2'b00;
        step(6);

        // Invalid ratios 0 and 1 never start; ratio 3 starts on the next edge.
        div_ratio = '0; load = 1'b1;
        exp_idle(0, 1); exp_idle(1, 1);
        step(1);
        load = 1'b0; enable = 2'b01;
        exp_idle(0, 3); exp_idle(1, 3);
        step(3);
        div_ratio = {8'd0, 8'd1}; load = 1'b1;
        exp_idle(0, 4); exp_idle(1, 4);
        step(1);
        load = 1'b0;
        step(3);
        div_ratio = {8'd0, 8'd3}; load = 1'b1;
        exp_idle(0, 1); exp_period(0, 3); exp_period(0, 3); exp_idle(1, 7);
        step(1);
        load = 1'b0;
        step(6);
        enable = 2'b00;
        exp_idle(0, 2); exp_idle(1, 2);
        step(2);

        // Asynchronous reset during the high phase of ratio 8.
        div_ratio = {8'd8, 8'd2}; load = 1'b1;
        exp_idle(0, 1); exp_idle(1, 1);
        step(1);
        load = 1'b0; enable = 2'b11;
        exp_period(0, 2);
        push(1, 2'b11); push(1, 2'b10);
        step(2);
        #1 reset = 1'b1;
        #1;
        check("async_rst_clk", 32'(clk_out), 32'd0);
        check("async_rst_tick", 32'(tick), 32'd0);
        #1 reset = 1'b0;
        exp_idle(0, 1); exp_idle(1, 1);
        step(1);
        exp_idle(0, 3); exp_idle(1, 3);
        step(3);
        div_ratio = {8'd8, 8'd2}; load = 1'b1;
        exp_idle(0, 1); exp_idle(1, 1);
        step(1);
        load = 1'b0;
        repeat (4) exp_period(0, 2);
        exp_period(1, 8);
        step(8);
        enable = 2'b00;
        exp_idle(0, 2); exp_idle(1, 2);
        step(2);

        // Maximum ratio on ch1 alongside odd ratio 3 on ch0.
        div_ratio = {8'd255, 8'd3}; load = 1'b1;
        exp_idle(0, 1); exp_idle(1, 1);
        step(1);
        load = 1'b0; enable = 2'b11;
        repeat (85) exp_period(0, 3);
        exp_period(1, 255);
        step(255);
        enable = 2'b00;
        exp_idle(0, 2); exp_idle(1, 2);
        step(2);

        for (int i = 0; i < 10 && (q0.size() + q1.size()) > 0; i++) @(negedge clk_in);
        check("scoreboard_drain", 32'(q0.size() + q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
